// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, optional
// two-entry skid buffer, flush-to-bubble and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 5,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  input  logic                  i_cnt_clr,
  output logic [CNT_WIDTH-1:0]  o_bubbles
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [CTRL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic accept_c;
  logic release_c;

  // Skid mode presents a registered ready; single-entry mode lets a draining head admit a new beat.
  assign o_ready   = (SKID != 0) ? ready_q : (!valid_q || i_ready);
  assign o_valid   = valid_q;
  assign o_data    = head_data_q;
  assign o_ctrl    = head_ctrl_q;
  assign o_bubbles = cnt_q;

  assign accept_c  = i_valid && o_ready;
  assign release_c = valid_q && i_ready;

  // Occupancy next-state, slot loads, control gating and bubble counting.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_EMPTY: begin
        if (accept_c) begin
          state_d     = S_ONE;
          head_data_d = i_data;
          head_ctrl_d = i_ctrl;
        end
      end
      S_ONE: begin
        if (accept_c && release_c) begin
          head_data_d = i_data;
          head_ctrl_d = i_ctrl;
        end else if (accept_c) begin
          // Only reachable with the skid buffer: downstream stalled, park the beat.
          state_d     = S_TWO;
          skid_data_d = i_data;
          skid_ctrl_d = i_ctrl;
        end else if (release_c) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (release_c) begin
          state_d     = S_ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush empties the stage; any beat accepted this cycle is dropped.
    if (i_flush) begin
      state_d = S_EMPTY;
    end

    // A bubble must never carry live control bits; payload is left untouched.
    if (state_d == S_EMPTY) begin
      head_ctrl_d = '0;
    end

    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_TWO);

    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (!valid_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, slot and counter registers; reset drops every held beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-entry
// instance driven from shared stimulus.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic [CW-1:0] i_ctrl;
  logic          i_flush;
  logic          i_ready;
  logic          i_cnt_clr;

  logic          s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ctrl;
  logic [NW-1:0] s_bub;

  logic          z_ready, z_valid;
  logic [DW-1:0] z_data;
  logic [CW-1:0] z_ctrl;
  logic [NW-1:0] z_bub;

  int total;
  int bad;

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(1), .CNT_WIDTH(NW)) dut_skid (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_data(i_data),
    .i_ctrl(i_ctrl), .i_flush(i_flush), .o_valid(s_valid), .i_ready(i_ready),
    .o_data(s_data), .o_ctrl(s_ctrl), .i_cnt_clr(i_cnt_clr), .o_bubbles(s_bub)
  );

  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID(0), .CNT_WIDTH(NW)) dut_single (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(z_ready), .i_data(i_data),
    .i_ctrl(i_ctrl), .i_flush(i_flush), .o_valid(z_valid), .i_ready(i_ready),
    .o_data(z_data), .o_ctrl(z_ctrl), .i_cnt_clr(i_cnt_clr), .o_bubbles(z_bub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_data = '0; i_ctrl = '0; i_flush = 1'b0;
    i_ready = 1'b0; i_cnt_clr = 1'b0;
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset state with nothing in flight.
    do_reset();
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_s_data",  32'(s_data),  32'd0);
    check("rst_z_ready", 32'(z_ready), 32'd1);

    // Reset with two beats held in the skid instance.
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; i_ctrl = 5'b10101;
    tick();
    i_data = 32'hB; i_ctrl = 5'b01010;
    tick();
    check("pre_rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_s_valid", 32'(s_valid), 32'd0);
    check("midrst_s_ctrl",  32'(s_ctrl),  32'd0);
    check("midrst_s_bub",   32'(s_bub),   32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_z_valid", 32'(z_valid), 32'd0);
    tick();
    rst = 1'b1;
    i_valid = 1'b0;

    // Full-rate stream, both modes.
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      i_data = 32'(k);
      i_ctrl = 5'(k);
      tick();
      check("stream_s_valid", 32'(s_valid), 32'd1);
      check("stream_s_data",  32'(s_data),  32'(k));
      check("stream_s_ready", 32'(s_ready), 32'd1);
      check("stream_z_data",  32'(z_data),  32'(k));
      check("stream_z_ready", 32'(z_ready), 32'd1);
    end
    i_valid = 1'b0;
    tick();
    check("stream_end_s_valid", 32'(s_valid), 32'd0);
    check("stream_end_z_valid", 32'(z_valid), 32'd0);

    // Backpressure: A head, B parked, C held upstream.
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; i_ctrl = 5'b00001;
    tick();
    check("bp_a_s_ready", 32'(s_ready), 32'd1);
    i_data = 32'hB; i_ctrl = 5'b00010;
    tick();
    check("bp_b_s_ready", 32'(s_ready), 32'd0);
    check("bp_b_s_data",  32'(s_data),  32'hA);
    check("bp_b_z_ready", 32'(z_ready), 32'd0);
    check("bp_b_z_data",  32'(z_data),  32'hA);
    i_data = 32'hC; i_ctrl = 5'b00011;
    tick();
    check("bp_c_s_ready", 32'(s_ready), 32'd0);
    check("bp_c_s_data",  32'(s_data),  32'hA);
    check("bp_c_s_ctrl",  32'(s_ctrl),  32'h1);
    i_ready = 1'b1;
    tick();
    check("bp_out_b_data",  32'(s_data),  32'hB);
    check("bp_out_b_ready", 32'(s_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    check("bp_out_c_data",  32'(s_data),  32'hC);
    check("bp_out_c_valid", 32'(s_valid), 32'd1);
    tick();
    check("bp_drain_valid", 32'(s_valid), 32'd0);
    check("bp_drain_ctrl",  32'(s_ctrl),  32'd0);
    check("bp_drain_data",  32'(s_data),  32'hC);

    // Flush with head A, skid B, C offered.
    do_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA; i_ctrl = 5'b11111;
    tick();
    i_data = 32'hB;
    tick();
    i_data = 32'hC; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_s_valid", 32'(s_valid), 32'd0);
    check("flush_s_ctrl",  32'(s_ctrl),  32'd0);
    check("flush_s_ready", 32'(s_ready), 32'd1);
    check("flush_z_valid", 32'(z_valid), 32'd0);
    check("flush_z_ready", 32'(z_ready), 32'd1);
    tick();
    check("flush_idle_s_valid", 32'(s_valid), 32'd0);
    i_valid = 1'b1; i_data = 32'hD; i_ctrl = 5'b00100;
    tick();
    i_valid = 1'b0; i_ready = 1'b1;
    check("flush_d_valid", 32'(s_valid), 32'd1);
    check("flush_d_data",  32'(s_data),  32'hD);
    check("flush_d_ctrl",  32'(s_ctrl),  32'h4);
    tick();
    check("flush_after_d_valid", 32'(s_valid), 32'd0);

    // Control gating on bubbles.
    do_reset();
    i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h55; i_ctrl = 5'b11111;
    tick();
    i_valid = 1'b0;
    check("gate_s_ctrl_live", 32'(s_ctrl), 32'h1F);
    check("gate_z_ctrl_live", 32'(z_ctrl), 32'h1F);
    tick();
    check("gate_s_ctrl_bub", 32'(s_ctrl), 32'd0);
    check("gate_s_data_bub", 32'(s_data), 32'h55);
    check("gate_z_ctrl_bub", 32'(z_ctrl), 32'd0);
    check("gate_z_data_bub", 32'(z_data), 32'h55);

    // Bubble counter saturation and clear.
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    check("cnt_3_s", 32'(s_bub), 32'd3);
    for (int k = 0; k < 17; k++) tick();
    check("cnt_sat_s", 32'(s_bub), 32'd15);
    check("cnt_sat_z", 32'(z_bub), 32'd15);
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    check("cnt_clr_s", 32'(s_bub), 32'd0);
    check("cnt_clr_z", 32'(z_bub), 32'd0);
    tick();
    check("cnt_inc_s", 32'(s_bub), 32'd1);
    check("cnt_inc_z", 32'(z_bub), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
